// File: rtl/alu_bist_driver.sv
// Built-in self-test initiator for the 32-bit single-cycle ALU: applies corner and LFSR
// vectors per operation, compares every response with a golden model and reports the outcome.
module alu_bist_driver #(
  parameter int          N_PER_OP = 16,
  parameter logic [31:0] SEED     = 32'hACE1_2468,
  parameter int          ERR_W    = 8,
  localparam int         IDX_W    = $clog2(5 * N_PER_OP)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  output logic [31:0]      srca,
  output logic [31:0]      srcb,
  output logic [2:0]       alucontrol,
  input  logic [31:0]      alu_y,
  input  logic             alu_zero,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [IDX_W-1:0] first_fail_idx
);

  localparam int          NVEC  = 5 * N_PER_OP;
  localparam int          SUB_W = $clog2(N_PER_OP);
  localparam logic [31:0] TAPS  = 32'h8020_0003;

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_CHECK, S_DONE} state_t;

  state_t           state, state_next;
  logic             go;
  logic [IDX_W-1:0] idx;
  logic [SUB_W-1:0] sub;
  logic [2:0]       op;
  logic [31:0]      lfsr, lfsr_next;
  logic [31:0]      vec_a, vec_b, exp_y;
  logic [2:0]       op_ctrl;
  logic             is_corner, last, mismatch;
  logic [ERR_W-1:0] err_next;

  // Vector generation: the first four vectors of each operation are fixed corners
  always_comb begin
    lfsr_next = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? TAPS : 32'd0);
    is_corner = (32'(sub) < 32'd4);
    vec_a     = lfsr;
    vec_b     = {lfsr[15:0], lfsr[31:16]} ^ 32'h5A5A_5A5A;
    if (is_corner) begin
      case (sub[1:0])
        2'd0:    begin vec_a = 32'h0000_0000; vec_b = 32'h0000_0000; end
        2'd1:    begin vec_a = 32'h0000_0000; vec_b = 32'hFFFF_FFFF; end
        2'd2:    begin vec_a = 32'h0000_0001; vec_b = 32'hFFFF_FFFF; end
        default: begin vec_a = 32'h8000_0000; vec_b = 32'h7FFF_FFFF; end
      endcase
    end
    case (op)
      3'd0:    op_ctrl = 3'b010;
      3'd1:    op_ctrl = 3'b110;
      3'd2:    op_ctrl = 3'b111;
      3'd3:    op_ctrl = 3'b000;
      default: op_ctrl = 3'b001;
    endcase
  end

  // Golden model evaluated on the operands currently presented to the ALU
  always_comb begin
    case (alucontrol)
      3'b000:  exp_y = srca & srcb;
      3'b001:  exp_y = srca | srcb;
      3'b010:  exp_y = srca + srcb;
      3'b110:  exp_y = srca - srcb;
      3'b111:  exp_y = {31'd0, $signed(srca) < $signed(srcb)};
      default: exp_y = 32'd0;
    endcase
    mismatch = (alu_y != exp_y) || (alu_zero != (exp_y == 32'd0));
    err_next = (mismatch && !(&err_count)) ? err_count + ERR_W'(1) : err_count;
    last     = (idx == IDX_W'(NVEC - 1));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    go         = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          go         = 1'b1;
          state_next = S_DRIVE;
        end
      end
      S_DRIVE: state_next = S_CHECK;
      S_CHECK: state_next = last ? S_DONE : S_DRIVE;
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath: the LFSR only advances on random vectors, so corners never consume sequence values
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      srca           <= 32'd0;
      srcb           <= 32'd0;
      alucontrol     <= 3'b000;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_fail_idx <= '0;
      idx            <= '0;
      sub            <= '0;
      op             <= 3'd0;
      lfsr           <= SEED;
    end else begin
      if (go) begin
        err_count      <= '0;
        first_fail_idx <= '0;
        done           <= 1'b0;
        pass           <= 1'b0;
        busy           <= 1'b1;
        idx            <= '0;
        sub            <= '0;
        op             <= 3'd0;
        lfsr           <= SEED;
      end
      if (state == S_DRIVE) begin
        srca       <= vec_a;
        srcb       <= vec_b;
        alucontrol <= op_ctrl;
        if (!is_corner) lfsr <= lfsr_next;
      end
      if (state == S_CHECK) begin
        err_count <= err_next;
        if (mismatch && (err_count == '0)) first_fail_idx <= idx;
        if (last) begin
          busy <= 1'b0;
          done <= 1'b1;
          pass <= (err_next == '0);
        end else begin
          idx <= idx + IDX_W'(1);
          if (sub == SUB_W'(N_PER_OP - 1)) begin
            sub <= '0;
            op  <= op + 3'd1;
          end else begin
            sub <= sub + SUB_W'(1);
          end
        end
      end
    end
  end

endmodule
